// File: rtl/emergency_conditioner_if.sv
// Detector input and conditioned request/status outputs of emergency_conditioner.
// slave is the conditioner's view; master is the view of whoever drives the detector and reads status.
interface emergency_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             i_sensor_raw;
    logic             o_emergency;
    logic             o_busy;
    logic             o_pending;
    logic [CNT_W-1:0] o_event_count;
    logic [CNT_W-1:0] o_drop_count;

    modport slave (
        input  i_sensor_raw,
        output o_emergency,
        output o_busy,
        output o_pending,
        output o_event_count,
        output o_drop_count
    );

    modport master (
        output i_sensor_raw,
        input  o_emergency,
        input  o_busy,
        input  o_pending,
        input  o_event_count,
        input  o_drop_count
    );
endinterface

// File: rtl/emergency_conditioner.sv
// Sync + debounce + rise-detect + rate-limit of the emergency detector into a one-cycle request.
// Latency: raw stable from sample edge k -> pulse after edge k+DEBOUNCE_CYCLES+1; no backpressure.
module emergency_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    emergency_conditioner_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int CW = $clog2(COOLDOWN_CYCLES) + 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CD_LAST  = CW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_COOLDOWN
    } state_t;

    logic             r_s1;
    logic             r_s2;
    logic             r_filt;
    logic [DW-1:0]    r_deb_cnt;
    logic [CW-1:0]    r_cd_cnt;
    state_t           r_state;
    logic             r_pending;
    logic [CNT_W-1:0] r_event_count;
    logic [CNT_W-1:0] r_drop_count;

    state_t           w_state_next;
    logic             w_pending_next;
    logic             w_drop_inc;
    logic             w_event_inc;
    logic             w_deb_done;
    logic             w_rise;
    logic             w_cd_done;

    // A completed mismatch run flips filt; it is a rise only when the new level is 1.
    assign w_deb_done  = (r_s2 != r_filt) && (r_deb_cnt == DEB_LAST);
    assign w_rise      = w_deb_done && r_s2;
    assign w_cd_done   = (r_cd_cnt == CD_LAST);
    assign w_event_inc = (w_state_next == S_PULSE) && (r_state != S_PULSE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_drop_inc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_state_next = S_PULSE;
            end
            S_PULSE: begin
                w_state_next = S_COOLDOWN;
                if (w_rise) begin
                    if (r_pending) w_drop_inc = 1'b1;
                    else           w_pending_next = 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (w_cd_done) begin
                    // A rise on the exit edge either re-queues behind the pending pulse or fires now.
                    if (r_pending) begin
                        w_state_next   = S_PULSE;
                        w_pending_next = w_rise;
                    end else if (w_rise) begin
                        w_state_next = S_PULSE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else if (w_rise) begin
                    if (r_pending) w_drop_inc = 1'b1;
                    else           w_pending_next = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_filt        <= 1'b0;
            r_deb_cnt     <= '0;
            r_cd_cnt      <= '0;
            r_pending     <= 1'b0;
            r_event_count <= '0;
            r_drop_count  <= '0;
        end else begin
            r_s1 <= bus.i_sensor_raw;
            r_s2 <= r_s1;

            if (r_s2 == r_filt) begin
                r_deb_cnt <= '0;
            end else if (w_deb_done) begin
                r_filt    <= r_s2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end

            if (r_state == S_PULSE)         r_cd_cnt <= '0;
            else if (r_state == S_COOLDOWN) r_cd_cnt <= r_cd_cnt + CW'(1);

            r_pending <= w_pending_next;

            if (w_event_inc && (r_event_count != '1)) r_event_count <= r_event_count + CNT_W'(1);
            if (w_drop_inc && (r_drop_count != '1))   r_drop_count  <= r_drop_count + CNT_W'(1);
        end
    end

    assign bus.o_emergency   = (r_state == S_PULSE);
    assign bus.o_busy        = (r_state != S_IDLE);
    assign bus.o_pending     = r_pending;
    assign bus.o_event_count = r_event_count;
    assign bus.o_drop_count  = r_drop_count;
endmodule
